// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: word width, reset/bubble constants, FSM state type and
// PC increment helper shared by the fetch_unit files.
package fetch_unit_pkg;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t RESET_PC  = 16'h0000;
  localparam word_t NOP_INSTR = 16'h0800;

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DRAIN,
    S_HALTED
  } state_t;

  // Sequential PC step, 16-bit modulo (16'hFFFE wraps to 16'h0000).
  function automatic word_t pc_inc(input word_t pc);
    return pc + word_t'(2);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: handshaking instruction-memory bus. master = fetch side,
// slave = memory side.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic  imem_rd;
  word_t imem_addr;
  word_t imem_data;
  logic  imem_done;

  modport master (
    output imem_rd,
    output imem_addr,
    input  imem_data,
    input  imem_done
  );

  modport slave (
    input  imem_rd,
    input  imem_addr,
    output imem_data,
    output imem_done
  );

endinterface

// File: rtl/fetch_unit_register_16bits.sv
// register_16bits: 16-bit register with write enable and synchronous,
// active-high reset to RESET_VAL. Holds the fetch PC.
module register_16bits
  import fetch_unit_pkg::*;
#(
  parameter word_t RESET_VAL = '0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  write_en,
  input  word_t d,
  output word_t q
);

  // Load d when enabled, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (write_en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the IF/ID latch. Owns the PC,
// drives the handshaking instruction memory, absorbs stalls, redirects and
// HALT. Optional macro FETCH_ALIGN_CHECK_EN enables odd-PC detection.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_in,
  input  logic          redirect_valid,
  input  word_t         redirect_pc,
  input  logic          halt_in,
  fetch_unit_if.master  imem,
  output word_t         instr_out,
  output word_t         pc_out,
  output logic          valid_out,
  output logic          latch_en,
  output logic          align_err
);

  state_t state;
  word_t  pc;
  word_t  pc_d;
  word_t  pc_plus2;
  word_t  drain_addr;
  word_t  buf_instr;
  logic   pc_we;
  logic   halt_pend;
  logic   odd;
  logic   redir;
  logic   access;
  logic   have_data;
  logic   present;

  register_16bits #(.RESET_VAL(RESET_PC)) u_pc (
    .clk      (clk),
    .rst      (rst),
    .write_en (pc_we),
    .d        (pc_d),
    .q        (pc)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  assign odd = (state == S_FETCH) && pc[0];

  // Sticky odd-PC flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      align_err <= 1'b0;
    end else if (odd && !redir) begin
      align_err <= 1'b1;
    end
  end
`else
  assign odd       = 1'b0;
  assign align_err = 1'b0;
`endif

  // Memory request, latch outputs and PC update for the current cycle.
  always_comb begin
    pc_plus2  = pc_inc(pc);
    redir     = redirect_valid && (state != S_HALTED);
    access    = ((state == S_FETCH) && !odd) || (state == S_WAIT) || (state == S_DRAIN);
    have_data = (((state == S_FETCH) && !odd) || (state == S_WAIT)) && imem.imem_done;
    present   = (have_data || (state == S_HOLD)) && !redir && !halt_in && !rst;

    valid_out = present;
    instr_out = NOP_INSTR;
    pc_out    = pc;
    if (present) begin
      instr_out = (state == S_HOLD) ? buf_instr : imem.imem_data;
      pc_out    = pc_plus2;
    end

    pc_we    = redir || (present && !stall_in);
    pc_d     = redir ? redirect_pc : pc_plus2;
    latch_en = ~stall_in | redirect_valid;
  end

  // DRAIN keeps presenting the abandoned address so it never moves mid-access.
  assign imem.imem_rd   = access;
  assign imem.imem_addr = (state == S_DRAIN) ? drain_addr : pc;

  // Fetch FSM: redirect beats halt, halt beats odd-PC/deliver/stall.
  // A request issued in FETCH that does not complete is treated like WAIT,
  // so a redirect or halt then drains it instead of moving the address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      halt_pend  <= 1'b0;
      drain_addr <= '0;
      buf_instr  <= '0;
    end else begin
      unique case (state)
        S_FETCH, S_WAIT: begin
          if (odd) begin
            state <= redir ? S_FETCH : S_HALTED;
          end else if (redir || halt_in) begin
            if (imem.imem_done) begin
              state <= redir ? S_FETCH : S_HALTED;
            end else begin
              state      <= S_DRAIN;
              drain_addr <= pc;
              halt_pend  <= !redir;
            end
          end else if (imem.imem_done) begin
            if (stall_in) begin
              state     <= S_HOLD;
              buf_instr <= imem.imem_data;
            end else begin
              state <= S_FETCH;
            end
          end else begin
            state <= S_WAIT;
          end
        end
        S_HOLD: begin
          if (redir || !stall_in) begin
            state <= halt_in && !redir ? S_HALTED : S_FETCH;
          end else if (halt_in) begin
            state <= S_HALTED;
          end
        end
        S_DRAIN: begin
          if (halt_in && !redir) begin
            halt_pend <= 1'b1;
          end
          if (imem.imem_done) begin
            state <= (halt_pend || (halt_in && !redir)) ? S_HALTED : S_FETCH;
          end
        end
        S_HALTED: begin
          state <= S_HALTED;
        end
        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that produces the instruction/PC pair written into the IF/ID pipeline latch. Owns the PC register and drives a handshaking instruction memory that may take one or many cycles per access. Absorbs decode-side stalls, branch/jump redirects and HALT, and presents the latch with either a valid instruction or a NOP bubble, plus the latch write enable.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_INSTR, 16'h0800, bubble encoding driven when no valid instruction is available

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall_in  in  1  hazard unit requests IF/ID hold this cycle
- redirect_valid  in  1  taken branch/jump/exception resolved downstream
- redirect_pc  in  16  target PC for redirect
- halt_in  in  1  HALT decoded; fetch stops permanently until reset
- imem_rd  out  1  instruction memory read request
- imem_addr  out  16  instruction memory address
- imem_data  in  16  instruction returned, valid when imem_done=1
- imem_done  in  1  access complete this cycle
- instr_out  out  16  instruction to IF/ID latch
- pc_out  out  16  PC+2 of instr_out, to IF/ID latch
- valid_out  out  1  instr_out is a real instruction (0 = NOP_INSTR)
- latch_en  out  1  write enable for IF/ID latch
- align_err  out  1  odd PC detected (only with FETCH_ALIGN_CHECK_EN)

## Operation
- State register: FETCH, WAIT, HOLD, DRAIN, HALTED.
- FETCH: imem_rd=1, imem_addr=pc. imem_done=1 -> deliver; else -> WAIT.
- WAIT: imem_rd=1, imem_addr=pc held stable until imem_done. On done -> deliver.
- Deliver: if stall_in=0: valid_out=1, instr_out=imem_data, pc_out=pc+2, pc<=pc+2, next FETCH. If stall_in=1: capture data/pc+2 into one-entry hold buffer, next HOLD.
- HOLD: imem_rd=0; instr_out/pc_out from buffer, valid_out=1. When stall_in=0: deliver buffer, pc<=pc+2, -> FETCH.
- Redirect (priority over stall and deliver): pc<=redirect_pc; hold buffer cleared; valid_out=0 this cycle. From FETCH/HOLD -> FETCH. From WAIT with imem_done=0 -> DRAIN (access must complete; its data is discarded).
- DRAIN: imem_rd=1 at old address until imem_done, data dropped, -> FETCH at new pc. A second redirect in DRAIN overwrites pc only.
- halt_in=1 (and no same-cycle redirect): -> HALTED after any outstanding access drains; HALTED issues no requests, valid_out=0.
- PC arithmetic: 16-bit modulo, 16'hFFFE+2 = 16'h0000.
- latch_en = ~stall_in | redirect_valid (flush writes NOP even when stalled).
- valid_out=0 implies instr_out=NOP_INSTR, pc_out=pc.

## Timing
- Reset: pc=RESET_PC, state=FETCH, buffer empty; first cycle after reset outputs valid_out=0, instr_out=NOP_INSTR, pc_out=RESET_PC, imem_rd=1 at RESET_PC.
- Reset mid-access overrides everything; memory owner handles its own abort.
- Hit latency: request and deliver in same cycle (one instruction/cycle sustained).
- Miss latency: N cycles of WAIT, deliver in cycle imem_done=1.
- instr_out/valid_out combinational from imem_data/buffer; pc and state registered.
- imem_addr never changes while imem_rd=1 and imem_done=0.

## Configuration
- FETCH_ALIGN_CHECK_EN defined: odd pc suppresses the request, forces valid_out=0, sets sticky align_err=1 (cleared only by rst), state -> HALTED.
- Undefined: pc[0] ignored (address passed as-is), align_err tied 0.

## Structure
- Shared package: state encoding constants, NOP_INSTR value, 16-bit word width.
- PC register is a register_16bits instance with writeEnable = pc update; no other sub-module.

## Test plan
- Reset, imem_done=1 every cycle -> imem_addr 0,2,4,6; pc_out 2,4,6,8; valid_out=1 from cycle 1.
- 3-cycle miss at 0x0010 -> imem_rd held 3 cycles at 0x0010, single deliver of pc_out=0x0012.
- stall_in high 2 cycles during hit -> HOLD, instr held, no imem_rd, then delivered once; pc advances exactly once.
- redirect_valid to 0x0100 during WAIT -> DRAIN; late data dropped (valid_out=0); next request at 0x0100.
- halt_in at pc 0x0020 -> no further imem_rd, valid_out=0 forever until rst.
- pc 0xFFFE hit -> pc wraps to 0x0000; with FETCH_ALIGN_CHECK_EN, redirect to 0x0101 -> align_err=1, HALTED.
